// File: rtl/caesar_stream_if.sv
// Valid/ready stream bundle for the Caesar decoder: ciphertext in, plaintext out.
// The slave modport is the decoder's view; the master modport is the producer/consumer side.
interface caesar_stream_if;
   logic [4:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] out_data;
   logic       out_err;
   logic       out_valid;
   logic       out_ready;

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_err, out_valid
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_err, out_valid
   );
endinterface

// File: rtl/caesar_stream_decoder.sv
// Caesar-cipher stream decoder: subtracts a latched key mod 26 from each ciphertext
// letter and buffers the plaintext in a small FIFO.
//
// state | meaning
// ------+--------------------------------------------------------------
// NOKEY | no key latched since reset; input side held off
// RUN   | key latched; letters are decoded and queued
module caesar_stream_decoder #(
   parameter int DEPTH   = 4,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [4:0]         key_in,
   input  logic               key_load,
   output logic               key_loaded,
   output logic [COUNT_W-1:0] char_count,
   caesar_stream_if.slave     s
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);

   typedef enum logic {ST_NOKEY = 1'b0, ST_RUN = 1'b1} state_t;

   state_t             state_q, state_d;
   logic               in_ready_c;
   logic               accept;
   logic               pop;
   logic               flush;

   logic [4:0]         key_q;
   logic               key_loaded_q;
   logic [COUNT_W-1:0] count_q;
   logic [5:0]         mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [OCC_W-1:0]   occ;
   logic               empty, full;

   logic [4:0]         key_red;
   logic [4:0]         dec_data;
   logic               in_bad;
   logic [5:0]         entry;

   assign empty = (occ == '0);
   assign full  = (occ == OCC_W'(DEPTH));

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!resetn) state_q <= ST_NOKEY;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (key_load) state_d = ST_RUN;
   end

   always_comb begin
      flush      = key_load;
      in_ready_c = (state_q == ST_RUN) && !full && !key_load;
      accept     = s.in_valid && in_ready_c;
      pop        = !empty && s.out_ready && !key_load;
   end

   // ---------------- decode ----------------
   // Key is below 26, so 26-key fits 5 bits and the wrapped sum never exceeds 25.
   assign key_red = (key_in >= 5'd26) ? (key_in - 5'd26) : key_in;
   assign in_bad  = (s.in_data >= 5'd26);

   always_comb begin
      dec_data = '0;
      if (s.in_data >= key_q) dec_data = s.in_data - key_q;
      else                    dec_data = s.in_data + (5'd26 - key_q);
      entry = in_bad ? {1'b1, 5'd31} : {1'b0, dec_data};
   end

   // ---------------- key / status ----------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         key_q        <= '0;
         key_loaded_q <= 1'b0;
         count_q      <= '0;
      end else if (flush) begin
         key_q        <= key_red;
         key_loaded_q <= 1'b1;
         count_q      <= '0;
      end else if (accept && !in_bad && (count_q != '1)) begin
         count_q      <= count_q + 1'b1;
      end
   end

   // ---------------- FIFO ----------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (accept)
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= entry;
   end

   // ---------------- outputs ----------------
   assign s.in_ready  = in_ready_c;
   assign s.out_valid = !empty;
   assign s.out_data  = empty ? 5'd0 : mem[rd_ptr][4:0];
   assign s.out_err   = empty ? 1'b0 : mem[rd_ptr][5];
   assign key_loaded  = key_loaded_q;
   assign char_count  = count_q;

endmodule

// File: tb/tb_caesar_stream_decoder.sv
// Directed + random bench for caesar_stream_decoder against a queue-based model.
module tb_caesar_stream_decoder;
   logic       clk = 1'b0;
   logic       resetn;
   logic [4:0] key_in;
   logic       key_load;
   logic       key_loaded;
   logic [7:0] char_count;

   caesar_stream_if sif();

   caesar_stream_decoder #(.DEPTH(4), .COUNT_W(8)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .key_in     (key_in),
      .key_load   (key_load),
      .key_loaded (key_loaded),
      .char_count (char_count),
      .s          (sif.slave)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Model state: effective key, loaded flag, queued {err,data}, letter count.
   int         m_key    = 0;
   bit         m_loaded = 1'b0;
   logic [5:0] m_q[$];
   int         m_cnt    = 0;
   bit         last_acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check mid-cycle, advance model at posedge.
   task automatic cycle(input bit rst, input bit kl, input logic [4:0] ki,
                        input bit iv, input logic [4:0] id, input bit ordy);
      bit         exp_rdy;
      logic [5:0] head;
      resetn         = !rst;
      key_load       = kl;
      key_in         = ki;
      sif.in_valid   = iv;
      sif.in_data    = id;
      sif.out_ready  = ordy;
      #1;
      exp_rdy = m_loaded && (m_q.size() < 4) && !kl;
      head    = (m_q.size() > 0) ? m_q[0] : 6'd0;
      if (!rst) chk("in_ready", {31'd0, sif.in_ready}, {31'd0, exp_rdy});
      chk("out_valid",  {31'd0, sif.out_valid}, (m_q.size() > 0) ? 32'd1 : 32'd0);
      chk("out_data",   {27'd0, sif.out_data},  {27'd0, head[4:0]});
      chk("out_err",    {31'd0, sif.out_err},   {31'd0, head[5]});
      chk("key_loaded", {31'd0, key_loaded},    {31'd0, m_loaded});
      chk("char_count", {24'd0, char_count},    m_cnt);
      last_acc = iv && exp_rdy && !rst;
      @(posedge clk);
      if (rst) begin
         m_key = 0; m_loaded = 1'b0; m_cnt = 0; m_q.delete();
      end else if (kl) begin
         m_key = int'(ki) % 26; m_loaded = 1'b1; m_cnt = 0; m_q.delete();
      end else begin
         if (ordy && m_q.size() > 0) void'(m_q.pop_front());
         if (iv && exp_rdy) begin
            if (id < 26) begin
               m_q.push_back({1'b0, 5'((int'(id) + 26 - m_key) % 26)});
               if (m_cnt < 255) m_cnt++;
            end else begin
               m_q.push_back({1'b1, 5'd31});
            end
         end
      end
      @(negedge clk);
   endtask

   int letters[6] = '{1, 2, 3, 4, 5, 6};
   int idx;

   initial begin
      resetn = 1'b0; key_load = 1'b0; key_in = '0;
      sif.in_valid = 1'b0; sif.in_data = '0; sif.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state and no-key hold-off
      cycle(0, 0, 0, 1, 5'd5, 1);
      chk("nokey_in_ready", {31'd0, sif.in_ready}, 32'd0);
      cycle(0, 0, 0, 1, 5'd9, 1);

      // key 3: 3,0,25 -> 0,23,22
      cycle(0, 1, 5'd3, 0, 0, 1);
      cycle(0, 0, 0, 1, 5'd3, 1);
      chk("t1_first_latency", {27'd0, sif.out_data}, 32'd0);
      cycle(0, 0, 0, 1, 5'd0, 1);
      cycle(0, 0, 0, 1, 5'd25, 1);
      repeat (3) cycle(0, 0, 0, 0, 0, 1);
      chk("t1_count", {24'd0, char_count}, 32'd3);

      // key_in 29 -> effective 3; key 0 -> identity
      cycle(0, 1, 5'd29, 0, 0, 1);
      cycle(0, 0, 0, 1, 5'd3, 0);
      chk("t2_key29", {27'd0, sif.out_data}, 32'd0);
      cycle(0, 1, 5'd0, 0, 0, 1);
      cycle(0, 0, 0, 1, 5'd7, 0);
      chk("t2_identity", {27'd0, sif.out_data}, 32'd7);
      cycle(0, 0, 0, 0, 0, 1);

      // Out-of-range input under key 5
      cycle(0, 1, 5'd5, 0, 0, 1);
      cycle(0, 0, 0, 1, 5'd27, 0);
      chk("t3_err", {31'd0, sif.out_err}, 32'd1);
      chk("t3_count", {24'd0, char_count}, 32'd0);
      cycle(0, 0, 0, 0, 0, 1);

      // Backpressure: 6 letters, FIFO fills at 4
      idx = 0;
      repeat (7) begin
         cycle(0, 0, 0, idx < 6, 5'(letters[(idx < 6) ? idx : 0]), 0);
         if (last_acc) idx++;
      end
      chk("t4_full_in_ready", {31'd0, sif.in_ready}, 32'd0);
      repeat (12) begin
         cycle(0, 0, 0, idx < 6, 5'(letters[(idx < 6) ? idx : 0]), 1);
         if (last_acc) idx++;
      end

      // Flush with two entries pending and an input offered
      cycle(0, 0, 0, 1, 5'd10, 0);
      cycle(0, 0, 0, 1, 5'd11, 0);
      cycle(0, 1, 5'd7, 1, 5'd12, 1);
      chk("t5_out_valid", {31'd0, sif.out_valid}, 32'd0);
      chk("t5_count", {24'd0, char_count}, 32'd0);

      // Random traffic
      repeat (400) begin
         cycle(0, ($urandom_range(0, 39) == 0), 5'($urandom_range(0, 31)),
               $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
               $urandom_range(0, 2) != 0);
      end

      // Reset mid-stream
      cycle(0, 0, 0, 1, 5'd4, 0);
      cycle(0, 0, 0, 1, 5'd8, 0);
      cycle(1, 0, 0, 1, 5'd9, 0);
      resetn = 1'b1; #1;
      chk("rst_out_valid",  {31'd0, sif.out_valid}, 32'd0);
      chk("rst_out_data",   {27'd0, sif.out_data},  32'd0);
      chk("rst_key_loaded", {31'd0, key_loaded},    32'd0);
      chk("rst_in_ready",   {31'd0, sif.in_ready},  32'd0);
      chk("rst_count",      {24'd0, char_count},    32'd0);
      cycle(0, 0, 0, 1, 5'd2, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
